// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//
// Four-source interrupt controller sitting beside the pipeline's Control
// decoder. Level sources are edge-detected into a pending register, gated by
// a mask, arbitrated, and presented to the core as a single IRQ request that
// the pipeline "takes" on a cycle when it can accept a PC redirect.
//
// Build option:
//   IRQ_PRIO_ROTATE_EN  undefined -> fixed priority (lowest index wins)
//                       defined   -> round-robin priority with a 2-bit pointer
//
// Handshake (IRQ / flush_ok):
//   IRQ is the valid and flush_ok the ready of a single transfer. The request
//   is taken on a rising edge where IRQ=1 and flush_ok=1. Once raised, IRQ and
//   irq_cause stay stable until the take, unless every enabled pending bit
//   disappears (cleared or masked), in which case the request is withdrawn
//   without a take. The handler return (eret) is only honoured in SERVICE.
// ---------------------------------------------------------------------------
module irq_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] src_req,
    input  logic       pc_kernel,
    input  logic       flush_ok,
    input  logic       eret,
    input  logic       mask_we,
    input  logic [3:0] mask_wdata,
    input  logic       clr_we,
    input  logic [3:0] clr_data,
    output logic       IRQ,
    output logic [1:0] irq_cause,
    output logic [3:0] irq_pending,
    output logic [3:0] irq_mask,
    output logic       busy,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_prev;
    logic [3:0] r_pending;
    logic [3:0] r_mask;
    logic [1:0] r_cause;

    logic [3:0] w_active;
    logic       w_any_active;
    logic [3:0] w_rise;
    logic [3:0] w_clr;
    logic [3:0] w_take_onehot;
    logic [1:0] w_winner;
    logic       w_take;
    logic       w_arm;

    // Arbitration always looks at the registered mask, so a mask write in the
    // same cycle only affects decisions from the next cycle on.
    assign w_active     = r_pending & r_mask;
    assign w_any_active = |w_active;

    // A rise is a sampled 0->1 transition of a level source.
    assign w_rise = src_req & ~r_prev;

`ifdef IRQ_PRIO_ROTATE_EN
    logic [1:0] r_ptr;
    logic [1:0] w_idx;

    // Round-robin pick: search from r_ptr upward modulo 4; scanning the
    // offsets from high to low lets the smallest offset overwrite the result.
    always_comb begin
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_active[w_idx]) begin
                w_winner = w_idx;
            end
        end
    end

    // The pointer moves just past the source that was taken.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr <= 2'd0;
        end else if (w_take) begin
            r_ptr <= r_cause + 2'd1;
        end
    end
`else
    // Fixed pick: lowest set index of the enabled pending bits wins.
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_active[i]) begin
                w_winner = 2'(i);
            end
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state, request/take strobes and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_arm        = 1'b0;
        IRQ          = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Kernel-mode code is never interrupted.
                if (w_any_active && !pc_kernel) begin
                    w_state_next = S_REQ;
                    w_arm        = 1'b1;
                end
            end
            S_REQ: begin
                // Only request a redirect while something enabled remains;
                // otherwise withdraw on the next edge.
                IRQ = w_any_active;
                if (!w_any_active) begin
                    w_state_next = S_IDLE;
                end else if (flush_ok) begin
                    w_take       = 1'b1;
                    w_state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                busy = 1'b1;
                if (eret) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pending bits to drop this edge: software clear plus the taken source.
    assign w_take_onehot = w_take ? (4'b0001 << r_cause) : 4'b0000;
    assign w_clr         = (clr_we ? clr_data : 4'b0000) | w_take_onehot;

    // Edge-detect history, pending (rise beats clear), mask and cause.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev    <= 4'b0000;
            r_pending <= 4'b0000;
            r_mask    <= 4'b0000;
            r_cause   <= 2'd0;
        end else begin
            r_prev    <= src_req;
            r_pending <= w_rise | (r_pending & ~w_clr);
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            if (w_arm) begin
                r_cause <= w_winner;
            end
        end
    end

    assign irq_cause   = r_cause;
    assign irq_pending = r_pending;
    assign irq_mask    = r_mask;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//
// Directed scenarios with hand-derived expectations, followed by a random
// run compared cycle by cycle against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_irq_controller;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] src_req;
    logic       pc_kernel;
    logic       flush_ok;
    logic       eret;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       clr_we;
    logic [3:0] clr_data;
    logic       IRQ;
    logic [1:0] irq_cause;
    logic [3:0] irq_pending;
    logic [3:0] irq_mask;
    logic       busy;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller dut (
        .clk         (clk),
        .reset       (reset),
        .src_req     (src_req),
        .pc_kernel   (pc_kernel),
        .flush_ok    (flush_ok),
        .eret        (eret),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .clr_we      (clr_we),
        .clr_data    (clr_data),
        .IRQ         (IRQ),
        .irq_cause   (irq_cause),
        .irq_pending (irq_pending),
        .irq_mask    (irq_mask),
        .busy        (busy),
        .o_dbg_state (dbg_state)
    );

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SERV = 2;

    int       m_phase;
    bit [3:0] m_pend;
    bit [3:0] m_mask;
    bit [3:0] m_prev;
    bit [1:0] m_cause;
    int       m_ptr;

    // Highest-priority enabled source, searching upward from base.
    function automatic bit [1:0] m_pick(bit [3:0] act, int base);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (base + k) % 4;
            if (act[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    // Apply one rising edge to the model using the inputs present at it.
    task automatic model_edge();
        bit [3:0] act;
        bit [3:0] np;
        bit       take;
        int       base;
        if (!reset) begin
            m_phase = PH_IDLE;
            m_pend  = 4'b0;
            m_mask  = 4'b0;
            m_prev  = 4'b0;
            m_cause = 2'd0;
            m_ptr   = 0;
            return;
        end
`ifdef IRQ_PRIO_ROTATE_EN
        base = m_ptr;
`else
        base = 0;
`endif
        act  = m_pend & m_mask;
        take = (m_phase == PH_REQ) && (act != 0) && flush_ok;
        np   = m_pend;
        for (int i = 0; i < 4; i++) begin
            if (src_req[i] && !m_prev[i]) np[i] = 1'b1;
            else if ((clr_we && clr_data[i]) || (take && i == int'(m_cause))) np[i] = 1'b0;
        end
        if (m_phase == PH_IDLE) begin
            if (act != 0 && !pc_kernel) begin
                m_phase = PH_REQ;
                m_cause = m_pick(act, base);
            end
        end else if (m_phase == PH_REQ) begin
            if (act == 0) begin
                m_phase = PH_IDLE;
            end else if (take) begin
                m_phase = PH_SERV;
                m_ptr   = (int'(m_cause) + 1) % 4;
            end
        end else begin
            if (eret) m_phase = PH_IDLE;
        end
        m_pend = np;
        if (mask_we) m_mask = mask_wdata;
        m_prev = src_req;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_quiet();
        eret     = 1'b0;
        mask_we  = 1'b0;
        clr_we   = 1'b0;
        clr_data = 4'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; src_req = 4'b0; pc_kernel = 1'b0; flush_ok = 1'b0;
        mask_wdata = 4'b0; drive_quiet();
        step(); step();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %0b want 0", IRQ); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_checks++; if (irq_pending !== 4'h0) begin n_fail++; $display("FAIL rst_pending: got %0h want 0", irq_pending); end
        n_checks++; if (irq_mask !== 4'h0) begin n_fail++; $display("FAIL rst_mask: got %0h want 0", irq_mask); end
        n_checks++; if (irq_cause !== 2'd0) begin n_fail++; $display("FAIL rst_cause: got %0d want 0", irq_cause); end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        mask_we = 1'b1; mask_wdata = 4'hF; flush_ok = 1'b1;
        step(); mask_we = 1'b0;
        n_checks++; if (irq_mask !== 4'hF) begin n_fail++; $display("FAIL lat_mask: got %0h want f", irq_mask); end
        src_req = 4'b0010;
        step(); // edge N
        n_checks++; if (irq_pending !== 4'b0010) begin n_fail++; $display("FAIL lat_pend_n: got %0h want 2", irq_pending); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL lat_irq_n: got %0b want 0", IRQ); end
        step(); // edge N+1
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL lat_irq_n1: got %0b want 1", IRQ); end
        n_checks++; if (irq_cause !== 2'd1) begin n_fail++; $display("FAIL lat_cause: got %0d want 1", irq_cause); end
        step(); // edge N+2: taken
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy: got %0b want 1", busy); end
        n_checks++; if (irq_pending[1] !== 1'b0) begin n_fail++; $display("FAIL lat_pend_clr: got %0b want 0", irq_pending[1]); end
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL lat_irq_srv: got %0b want 0", IRQ); end
        eret = 1'b1; step(); eret = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_eret: got %0b want 0", busy); end
        src_req = 4'b0; step();
    endtask

    task automatic test_stall();
        flush_ok = 1'b0; src_req = 4'b0100;
        step();
        n_checks++; if (irq_pending !== 4'b0100) begin n_fail++; $display("FAIL stall_pend: got %0h want 4", irq_pending); end
        step();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL stall_irq[%0d]: got %0b want 1", i, IRQ); end
            n_checks++; if (irq_cause !== 2'd2) begin n_fail++; $display("FAIL stall_cause[%0d]: got %0d want 2", i, irq_cause); end
            step();
        end
        flush_ok = 1'b1;
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_take: got %0b want 1", busy); end
        n_checks++; if (irq_pending !== 4'b0) begin n_fail++; $display("FAIL stall_pend_clr: got %0h want 0", irq_pending); end
        eret = 1'b1; step(); eret = 1'b0;
        src_req = 4'b0; step();
    endtask

    task automatic test_priority();
        flush_ok = 1'b0; src_req = 4'b1010;
        step();
        n_checks++; if (irq_pending !== 4'b1010) begin n_fail++; $display("FAIL prio_pend: got %0h want a", irq_pending); end
        step();
        n_checks++; if (irq_cause !== 2'd1) begin n_fail++; $display("FAIL prio_first: got %0d want 1", irq_cause); end
        flush_ok = 1'b1; step();
        n_checks++; if (irq_pending !== 4'b1000) begin n_fail++; $display("FAIL prio_pend2: got %0h want 8", irq_pending); end
        flush_ok = 1'b0; eret = 1'b1; step(); eret = 1'b0;
        step();
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL prio_irq2: got %0b want 1", IRQ); end
        n_checks++; if (irq_cause !== 2'd3) begin n_fail++; $display("FAIL prio_second: got %0d want 3", irq_cause); end
        flush_ok = 1'b1; step();
        eret = 1'b1; step(); eret = 1'b0;
        flush_ok = 1'b0; src_req = 4'b1000; step();
        src_req = 4'b1010; step();
        step();
        n_checks++; if (irq_cause !== 2'd1) begin n_fail++; $display("FAIL prio_third: got %0d want 1", irq_cause); end
        flush_ok = 1'b1; step();
        eret = 1'b1; step(); eret = 1'b0;
        src_req = 4'b0; step();
    endtask

    task automatic test_clear_in_req();
        flush_ok = 1'b0; src_req = 4'b0001;
        step(); step();
        n_checks++; if (IRQ !== 1'b1 || irq_cause !== 2'd0) begin n_fail++; $display("FAIL clr_req: got irq=%0b cause=%0d want 1/0", IRQ, irq_cause); end
        clr_we = 1'b1; clr_data = 4'b0001; step(); clr_we = 1'b0; clr_data = 4'b0;
        n_checks++; if (irq_pending !== 4'b0) begin n_fail++; $display("FAIL clr_pend: got %0h want 0", irq_pending); end
        step();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL clr_irq: got %0b want 0", IRQ); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %0b want 0", busy); end
        flush_ok = 1'b1; step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy2: got %0b want 0", busy); end
        src_req = 4'b0; step();
    endtask

    task automatic test_rise_vs_clear();
        pc_kernel = 1'b1; flush_ok = 1'b1; src_req = 4'b0001;
        clr_we = 1'b1; clr_data = 4'b0001;
        step(); clr_we = 1'b0; clr_data = 4'b0;
        n_checks++; if (irq_pending !== 4'b0001) begin n_fail++; $display("FAIL rvc_pend: got %0h want 1", irq_pending); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (IRQ !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL kern_hold[%0d]: got irq=%0b busy=%0b want 0/0", i, IRQ, busy); end
        end
        pc_kernel = 1'b0; step();
        n_checks++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL kern_release: got %0b want 1", IRQ); end
        step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kern_take: got %0b want 1", busy); end
        eret = 1'b1; step(); eret = 1'b0;
        src_req = 4'b0; step();
    endtask

    task automatic test_reset_in_service();
        flush_ok = 1'b1; src_req = 4'b1000;
        step(); step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rsv_busy: got %0b want 1", busy); end
        src_req = 4'b1100; step();
        n_checks++; if (busy !== 1'b1 || irq_pending !== 4'b0100) begin n_fail++; $display("FAIL rsv_accum: got busy=%0b pend=%0h want 1/4", busy, irq_pending); end
        reset = 1'b0; step();
        n_checks++; if (busy !== 1'b0 || IRQ !== 1'b0) begin n_fail++; $display("FAIL rsv_abort: got busy=%0b irq=%0b want 0/0", busy, IRQ); end
        n_checks++; if (irq_mask !== 4'h0 || irq_pending !== 4'h0) begin n_fail++; $display("FAIL rsv_regs: got mask=%0h pend=%0h want 0/0", irq_mask, irq_pending); end
        reset = 1'b1; step();
        n_checks++; if (irq_pending !== 4'b1100) begin n_fail++; $display("FAIL rsv_first_rise: got %0h want c", irq_pending); end
        step();
        n_checks++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL rsv_masked: got %0b want 0", IRQ); end
        src_req = 4'b0; step();
    endtask

    task automatic test_random();
        bit skip_irq;
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) src_req[i] = ~src_req[i];
            pc_kernel  = ($urandom_range(0, 3) == 0);
            flush_ok   = $urandom_range(0, 1) == 1;
            eret       = ($urandom_range(0, 7) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            clr_we     = ($urandom_range(0, 7) == 0);
            clr_data   = 4'($urandom_range(0, 15));
            step();
            skip_irq = (m_phase == PH_REQ) && ((m_pend & m_mask) == 0);
            n_checks++; if (irq_pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend@%0d: got %0h want %0h", c, irq_pending, m_pend); end
            n_checks++; if (irq_mask !== m_mask) begin n_fail++; $display("FAIL rnd_mask@%0d: got %0h want %0h", c, irq_mask, m_mask); end
            n_checks++; if (busy !== (m_phase == PH_SERV)) begin n_fail++; $display("FAIL rnd_busy@%0d: got %0b want %0b", c, busy, m_phase == PH_SERV); end
            n_checks++; if (irq_cause !== m_cause) begin n_fail++; $display("FAIL rnd_cause@%0d: got %0d want %0d", c, irq_cause, m_cause); end
            if (!skip_irq) begin
                n_checks++; if (IRQ !== (m_phase == PH_REQ)) begin n_fail++; $display("FAIL rnd_irq@%0d: got %0b want %0b", c, IRQ, m_phase == PH_REQ); end
            end
        end
        drive_quiet(); reset = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_priority();
        test_clear_in_req();
        test_rise_vs_clear();
        test_reset_in_service();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
